// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases NUM_DOMAINS reset lines one by one, each gated by
// the previous domain's ack, with a watchdog that forces everything back into reset.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int DLY_W       = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           SW_RST_REQ,
  input  logic [DLY_W-1:0]               DLY_CFG,
  input  logic [NUM_DOMAINS-1:0]         ACK,
  output logic [NUM_DOMAINS-1:0]         RST_OUT,
  output logic                           SEQ_DONE,
  output logic                           SEQ_ERR,
  output logic [$clog2(NUM_DOMAINS)-1:0] CUR_STAGE
);

  localparam int STG_W  = $clog2(NUM_DOMAINS);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int CNT_A  = (DLY_W > HOLD_W) ? DLY_W : HOLD_W;
  // One counter serves hold, gap and ack-timeout, so it must fit the widest of the three.
  localparam int CNT_W  = (CNT_A > TO_W) ? CNT_A : TO_W;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [STG_W-1:0] STG_ONE   = STG_W'(1);
  localparam logic [STG_W-1:0] STG_ZERO  = STG_W'(0);
  localparam logic [STG_W-1:0] STG_LAST  = STG_W'(NUM_DOMAINS - 1);

  localparam logic [2:0] ST_HOLD     = 3'd0;
  localparam logic [2:0] ST_GAP      = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  logic [2:0]             state_r,   state_s;
  logic [CNT_W-1:0]       cnt_r,     cnt_s;
  logic [DLY_W-1:0]       dly_r,     dly_s;
  logic [NUM_DOMAINS-1:0] rst_out_r, rst_out_s;
  logic                   done_r,    done_s;
  logic                   err_r,     err_s;
  logic [STG_W-1:0]       stage_r,   stage_s;

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    dly_s     = dly_r;
    rst_out_s = rst_out_r;
    done_s    = done_r;
    err_s     = err_r;
    stage_s   = stage_r;
    if (SW_RST_REQ) begin
      state_s   = ST_HOLD;
      cnt_s     = CNT_ZERO;
      rst_out_s = {NUM_DOMAINS{1'b1}};
      done_s    = 1'b0;
      err_s     = 1'b0;
      stage_s   = STG_ZERO;
    end else begin
      case (state_r)
        ST_HOLD: begin
          rst_out_s = {NUM_DOMAINS{1'b1}};
          done_s    = 1'b0;
          if (cnt_r == HOLD_LAST) begin
            dly_s   = DLY_CFG;
            stage_s = STG_ZERO;
            cnt_s   = CNT_ZERO;
            state_s = ST_GAP;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_r == CNT_W'(dly_r)) begin
            rst_out_s[stage_r] = 1'b0;
            cnt_s              = CNT_ZERO;
            state_s            = ST_WAIT_ACK;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_ACK: begin
          if (ACK[stage_r]) begin
            cnt_s = CNT_ZERO;
            if (stage_r == STG_LAST) begin
              state_s = ST_RUN;
              done_s  = 1'b1;
            end else begin
              stage_s = stage_r + STG_ONE;
              state_s = ST_GAP;
            end
          end else if (cnt_r == TO_LAST) begin
            rst_out_s = {NUM_DOMAINS{1'b1}};
            err_s     = 1'b1;
            cnt_s     = CNT_ZERO;
            state_s   = ST_FAULT;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          rst_out_s = {NUM_DOMAINS{1'b0}};
          done_s    = 1'b1;
        end
        ST_FAULT: begin
          rst_out_s = {NUM_DOMAINS{1'b1}};
          done_s    = 1'b0;
          err_s     = 1'b1;
        end
        default: begin
          // An illegal encoding restarts the sequence from a fully-reset state.
          state_s   = ST_HOLD;
          cnt_s     = CNT_ZERO;
          rst_out_s = {NUM_DOMAINS{1'b1}};
          done_s    = 1'b0;
          err_s     = 1'b0;
          stage_s   = STG_ZERO;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= ST_HOLD;
      cnt_r     <= CNT_ZERO;
      dly_r     <= {DLY_W{1'b0}};
      rst_out_r <= {NUM_DOMAINS{1'b1}};
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      stage_r   <= STG_ZERO;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      dly_r     <= dly_s;
      rst_out_r <= rst_out_s;
      done_r    <= done_s;
      err_r     <= err_s;
      stage_r   <= stage_s;
    end
  end

  assign RST_OUT   = rst_out_r;
  assign SEQ_DONE  = done_r;
  assign SEQ_ERR   = err_r;
  assign CUR_STAGE = stage_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: edge-numbered vector table plus
// hand-written sequences for timeout, software request and async reset.
module tb_rst_seq_ctrl;

  logic       CLK_tb;
  logic       RST_tb;
  logic       SW_RST_REQ_tb;
  logic [7:0] DLY_CFG_tb;
  logic [3:0] ACK_tb;
  logic [3:0] RST_OUT_tb;
  logic       SEQ_DONE_tb;
  logic       SEQ_ERR_tb;
  logic [1:0] CUR_STAGE_tb;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  typedef struct {
    logic       restart;
    logic [7:0] dly;
    logic [3:0] ack;
    int         edge_n;
    logic [3:0] exp_rst;
    logic       exp_done;
    logic       exp_err;
    logic [1:0] exp_stg;
  } vec_t;

  vec_t vecs[$];

  rst_seq_ctrl #(
    .NUM_DOMAINS(4), .DLY_W(8), .HOLD_CYCLES(16), .TIMEOUT(255)
  ) dut (
    .CLK       (CLK_tb),
    .RST       (RST_tb),
    .SW_RST_REQ(SW_RST_REQ_tb),
    .DLY_CFG   (DLY_CFG_tb),
    .ACK       (ACK_tb),
    .RST_OUT   (RST_OUT_tb),
    .SEQ_DONE  (SEQ_DONE_tb),
    .SEQ_ERR   (SEQ_ERR_tb),
    .CUR_STAGE (CUR_STAGE_tb)
  );

  initial CLK_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] r, input logic d,
                           input logic e, input logic [1:0] s);
    check({tag, " rst_out"}, {28'd0, RST_OUT_tb}, {28'd0, r});
    check({tag, " done"},    {31'd0, SEQ_DONE_tb}, {31'd0, d});
    check({tag, " err"},     {31'd0, SEQ_ERR_tb}, {31'd0, e});
    check({tag, " stage"},   {30'd0, CUR_STAGE_tb}, {30'd0, s});
  endtask

  task automatic tick();
    @(posedge CLK_tb);
    edge_cnt++;
    #1;
  endtask

  task automatic run_to(input int e);
    while (edge_cnt < e) tick();
  endtask

  // Assert RST, verify the reset state, release it on a falling edge.
  task automatic do_reset();
    @(negedge CLK_tb);
    RST_tb = 1'b1;
    #2;
    check_all("reset", 4'hF, 1'b0, 1'b0, 2'd0);
    @(negedge CLK_tb);
    RST_tb   = 1'b0;
    edge_cnt = 0;
  endtask

  // which 0..3: wait for RST_OUT[which] low; 4: wait for SEQ_DONE.
  task automatic count_until(input int which, input int limit, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      tick();
      n++;
      hit = (which < 4) ? (RST_OUT_tb[which] == 1'b0) : SEQ_DONE_tb;
    end
  endtask

  task automatic add(input logic r, input logic [7:0] d, input logic [3:0] a, input int e,
                     input logic [3:0] xr, input logic xd, input logic xe, input logic [1:0] xs);
    vec_t v;
    v.restart = r; v.dly = d; v.ack = a; v.edge_n = e;
    v.exp_rst = xr; v.exp_done = xd; v.exp_err = xe; v.exp_stg = xs;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    RST_tb        = 1'b1;
    SW_RST_REQ_tb = 1'b0;
    DLY_CFG_tb    = 8'd2;
    ACK_tb        = 4'hF;

    // Gap 2, all acks high
    add(1'b1, 8'd2, 4'hF,  1, 4'hF, 1'b0, 1'b0, 2'd0);
    add(1'b0, 8'd2, 4'hF, 16, 4'hF, 1'b0, 1'b0, 2'd0);
    add(1'b0, 8'd2, 4'hF, 18, 4'hF, 1'b0, 1'b0, 2'd0);
    add(1'b0, 8'd2, 4'hF, 19, 4'hE, 1'b0, 1'b0, 2'd0);
    add(1'b0, 8'd2, 4'hF, 20, 4'hE, 1'b0, 1'b0, 2'd1);
    add(1'b0, 8'd2, 4'hF, 22, 4'hE, 1'b0, 1'b0, 2'd1);
    add(1'b0, 8'd2, 4'hF, 23, 4'hC, 1'b0, 1'b0, 2'd1);
    add(1'b0, 8'd2, 4'hF, 27, 4'h8, 1'b0, 1'b0, 2'd2);
    add(1'b0, 8'd2, 4'hF, 31, 4'h0, 1'b0, 1'b0, 2'd3);
    add(1'b0, 8'd2, 4'hF, 32, 4'h0, 1'b1, 1'b0, 2'd3);
    add(1'b0, 8'd2, 4'h0, 40, 4'h0, 1'b1, 1'b0, 2'd3);
    // Gap 0
    add(1'b1, 8'd0, 4'hF, 16, 4'hF, 1'b0, 1'b0, 2'd0);
    add(1'b0, 8'd0, 4'hF, 17, 4'hE, 1'b0, 1'b0, 2'd0);
    add(1'b0, 8'd0, 4'hF, 18, 4'hE, 1'b0, 1'b0, 2'd1);
    add(1'b0, 8'd0, 4'hF, 19, 4'hC, 1'b0, 1'b0, 2'd1);
    add(1'b0, 8'd0, 4'hF, 21, 4'h8, 1'b0, 1'b0, 2'd2);
    add(1'b0, 8'd0, 4'hF, 23, 4'h0, 1'b0, 1'b0, 2'd3);
    add(1'b0, 8'd0, 4'hF, 24, 4'h0, 1'b1, 1'b0, 2'd3);
    // Gap changed from 2 to 7 after bit0 release: current sequence keeps 2
    add(1'b1, 8'd2, 4'hF, 19, 4'hE, 1'b0, 1'b0, 2'd0);
    add(1'b0, 8'd7, 4'hF, 20, 4'hE, 1'b0, 1'b0, 2'd1);
    add(1'b0, 8'd7, 4'hF, 23, 4'hC, 1'b0, 1'b0, 2'd1);
    add(1'b0, 8'd7, 4'hF, 27, 4'h8, 1'b0, 1'b0, 2'd2);
    add(1'b0, 8'd7, 4'hF, 32, 4'h0, 1'b1, 1'b0, 2'd3);

    foreach (vecs[i]) begin
      DLY_CFG_tb = vecs[i].dly;
      ACK_tb     = vecs[i].ack;
      if (vecs[i].restart) do_reset();
      run_to(vecs[i].edge_n);
      check_all($sformatf("vec%0d", i), vecs[i].exp_rst, vecs[i].exp_done,
                vecs[i].exp_err, vecs[i].exp_stg);
    end

    // Next sequence picks up gap 7
    ACK_tb = 4'hF;
    SW_RST_REQ_tb = 1'b1;
    tick();
    check_all("s6 req", 4'hF, 1'b0, 1'b0, 2'd0);
    SW_RST_REQ_tb = 1'b0;
    count_until(0, 100, n);
    check("s6 bit0 edges", n, 24);
    count_until(1, 100, n);
    check("s6 bit1 edges", n, 9);
    count_until(4, 200, n);
    check("s6 done", {31'd0, SEQ_DONE_tb}, 32'd1);

    // Software request held 5 cycles while running
    DLY_CFG_tb    = 8'd2;
    SW_RST_REQ_tb = 1'b1;
    tick();
    check_all("s4 req1", 4'hF, 1'b0, 1'b0, 2'd0);
    repeat (4) tick();
    check_all("s4 req5", 4'hF, 1'b0, 1'b0, 2'd0);
    SW_RST_REQ_tb = 1'b0;
    count_until(0, 100, n);
    check("s4 bit0 edges", n, 19);
    count_until(4, 100, n);
    check("s4 done edges", n, 13);

    // ACK[1] stuck low: timeout fault, then recovery
    DLY_CFG_tb = 8'd2;
    ACK_tb     = 4'b0001;
    do_reset();
    run_to(23);
    check_all("s3 bit1", 4'hC, 1'b0, 1'b0, 2'd1);
    run_to(277);
    check_all("s3 pre-timeout", 4'hC, 1'b0, 1'b0, 2'd1);
    run_to(278);
    check_all("s3 timeout", 4'hF, 1'b0, 1'b1, 2'd1);
    ACK_tb = 4'hF;
    run_to(290);
    check_all("s3 fault hold", 4'hF, 1'b0, 1'b1, 2'd1);
    SW_RST_REQ_tb = 1'b1;
    tick();
    check_all("s3 req", 4'hF, 1'b0, 1'b0, 2'd0);
    SW_RST_REQ_tb = 1'b0;
    count_until(4, 100, n);
    check("s3 rerun done edges", n, 32);
    check("s3 rerun err", {31'd0, SEQ_ERR_tb}, 32'd0);

    // Async reset while waiting for ack at stage 2
    ACK_tb = 4'b0011;
    do_reset();
    run_to(30);
    check_all("s5 wait2", 4'h8, 1'b0, 1'b0, 2'd2);
    #2;
    RST_tb = 1'b1;
    #1;
    check_all("s5 async", 4'hF, 1'b0, 1'b0, 2'd0);
    @(negedge CLK_tb);
    RST_tb   = 1'b0;
    edge_cnt = 0;
    ACK_tb   = 4'hF;
    run_to(18);
    check_all("s5 e18", 4'hF, 1'b0, 1'b0, 2'd0);
    run_to(19);
    check_all("s5 e19", 4'hE, 1'b0, 1'b0, 2'd0);
    run_to(31);
    check_all("s5 e31", 4'h0, 1'b0, 1'b0, 2'd3);
    run_to(32);
    check_all("s5 e32", 4'h0, 1'b1, 1'b0, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer that releases NUM_DOMAINS downstream reset lines one at a time, in a fixed order, from a single clock.
- Sits after the system reset synchronizer. It drives the per-domain reset inputs of SYS_CTRL, register file, ALU and UART (or similar).
- Each domain must acknowledge it is out of reset before the next is released. A missing ack forces all domains back into reset and flags an error.
- A software request re-runs the whole sequence.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset outputs; index 0 is released first.
- DLY_W, 8, width of the DLY_CFG gap value.
- HOLD_CYCLES, 16, minimum cycles all outputs stay asserted after any reset or request; must be >= 1.
- TIMEOUT, 255, cycles to wait for ACK[k] before declaring a fault; must be >= 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset (already synchronized for deassertion upstream).
- SW_RST_REQ  in  1  level-sensitive software reset request, active-high.
- DLY_CFG  in  DLY_W  gap cycles between an ack and the next release.
- ACK  in  NUM_DOMAINS  per-domain "out of reset / ready" indication.
- RST_OUT  out  NUM_DOMAINS  per-domain reset, active-high (1 = held in reset); registered.
- SEQ_DONE  out  1  all domains released and acknowledged; registered.
- SEQ_ERR  out  1  sticky ack-timeout flag; registered.
- CUR_STAGE  out  $clog2(NUM_DOMAINS)  index of the domain currently being released; registered.

Behaviour:
- RST=1 (async) sets the following, immediately and for as long as RST is held:
  - RST_OUT = all ones
  - SEQ_DONE = 0, SEQ_ERR = 0, CUR_STAGE = 0
  - state = HOLD, counters = 0
- Posedges are numbered from 1, counting the first posedge after RST falls.
- States: HOLD, GAP, WAIT_ACK, RUN, FAULT.
- HOLD:
  - RST_OUT all ones; counter advances each edge.
  - On edge HOLD_CYCLES: latch DLY_CFG into dly_reg, set CUR_STAGE=0, go to GAP.
  - SW_RST_REQ=1 clears the counter, so HOLD persists while the request is held.
- GAP:
  - Counts 0..dly_reg. On the edge where count == dly_reg, clear RST_OUT[CUR_STAGE] and go to WAIT_ACK.
  - So the first release occurs at edge HOLD_CYCLES+dly_reg+1; DLY_CFG=0 releases on the first GAP edge.
- WAIT_ACK:
  - On the first edge that samples ACK[CUR_STAGE]=1 (including the first WAIT_ACK edge):
    - if CUR_STAGE == NUM_DOMAINS-1: go to RUN and set SEQ_DONE=1 on that edge;
    - otherwise: CUR_STAGE+1, go to GAP.
  - The next release therefore occurs dly_reg+1 edges after the ack edge.
  - ACK bits of other indices are ignored.
  - If TIMEOUT consecutive edges sample ACK[CUR_STAGE]=0: on the TIMEOUT-th edge set RST_OUT = all ones, SEQ_ERR=1, go to FAULT.
- RUN:
  - RST_OUT all zeros, SEQ_DONE=1. ACK deassertion is ignored.
- FAULT:
  - RST_OUT all ones, SEQ_DONE=0, SEQ_ERR=1. Stays until SW_RST_REQ.
- SW_RST_REQ=1 sampled in GAP, WAIT_ACK, RUN or FAULT, on that edge:
  - RST_OUT = all ones, SEQ_DONE=0, SEQ_ERR=0, CUR_STAGE=0;
  - counters cleared; go to HOLD.
- dly_reg changes only in HOLD. DLY_CFG changes mid-sequence take effect on the next sequence only.
- CUR_STAGE holds its last value in RUN and FAULT.
- Already-released domains never re-assert except on RST, SW_RST_REQ or a fault, and then all domains assert together.

Test Plan (defaults, NUM_DOMAINS=4):
1. Release RST; DLY_CFG=2; ACK tied 4'hF → RST_OUT falls bit-by-bit:
   - bit0 at edge 19, bit1 at 23, bit2 at 27, bit3 at 31;
   - SEQ_DONE=1 at edge 32; SEQ_ERR=0 throughout.
2. DLY_CFG=0, ACK tied 4'hF → bit0 at edge 17, bits 1–3 at 19, 21, 23; SEQ_DONE at 24.
3. DLY_CFG=2; ACK[0]=1 with ACK[1] stuck 0 → bit1 released at edge 23, then:
   - 255 edges later, RST_OUT=4'hF and SEQ_ERR=1, CUR_STAGE=1;
   - a 1-cycle SW_RST_REQ pulse clears SEQ_ERR and the sequence reruns to SEQ_DONE.
4. In RUN, hold SW_RST_REQ for 5 cycles → RST_OUT=4'hF on the first sampled edge and SEQ_DONE=0; bit0 releases HOLD_CYCLES+DLY_CFG+1 edges after the request drops.
5. Assert RST asynchronously (mid-clock) while in WAIT_ACK at stage 2 → RST_OUT=4'hF, CUR_STAGE=0, SEQ_DONE=0 without waiting for a clock edge; after release, full sequence timing matches scenario 1.
6. Change DLY_CFG from 2 to 7 after bit0 releases → remaining gaps stay 2 cycles; the next sequence, after SW_RST_REQ, uses 7.
